perceptron_result_packer: RTL and testbench
===========================================

// Module: perceptron_result_packer
// PURPOSE
// - Stage directly downstream of the perceptron top. Consumes its 1-bit decisions (Y) over a val/rdy handshake.
// - Packs decisions LSB-first into PACK-bit words and emits each word over a val/rdy handshake.
// - Counts accepted Y=1 decisions. A flush emits a partial word.
// PARAMETERS
// - PACK   default 8   decisions per word; legal range 2..32
// - CNT_W  default 16  width of the saturating ones counter
// PORTS
// - clk         in   1                  clock; all flops on rising edge
// - reset       in   1                  asynchronous, active-low reset (0 = reset)
// - val_i       in   1                  upstream decision valid
// - rdy_o       out  1                  packer can accept a decision
// - Y_i         in   1                  decision bit from the perceptron
// - flush_i     in   1                  emit the partial word (single-cycle pulse or level)
// - val_o       out  1                  word_o/len_o valid
// - rdy_i       in   1                  downstream accepts the word
// - word_o      out  PACK               packed decisions; bit k = k-th decision of the word
// - len_o       out  $clog2(PACK+1)     number of valid bits in word_o (1..PACK)
// - ones_cnt_o  out  CNT_W              running count of accepted Y_i=1
// - ovf_o       out  1                  sticky flag: ones counter saturated
// BEHAVIOUR
// - Accept = val_i & rdy_o. Emit = val_o & rdy_i.
// - Assembly register sr[PACK-1:0] and fill count n. Single-entry output register holds word_o, len_o and val_o.
// - Output slot free = !val_o | rdy_i.
// - FSM states:
//   - S_FILL: rdy_o=1. An accepted bit is written to sr[n] and n increments.
//   - S_STALL: word complete, waiting for the output slot. rdy_o=0.
//   - S_FLUSH: flush requested with n>0, waiting for the output slot. rdy_o=0.
// - Word complete: accept with n==PACK-1.
//   - Slot free: load word_o={Y_i,sr[PACK-2:0]}, len_o=PACK. val_o=1 next cycle; n=0; stay in S_FILL.
//   - Slot busy: go to S_STALL.
// - Throughput and latency:
//   - Full throughput: one decision per cycle when rdy_i=1.
//   - val_o rises 1 cycle after the PACK-th accept.
// - S_STALL: when the slot is free, load the word (len_o=PACK), n=0, go to S_FILL.
// - Flush in S_FILL:
//   - The effective count includes a bit accepted in the same cycle.
//   - Effective count 0: flush ignored; an empty word is never emitted.
//   - Effective count >0 and slot free: load the word, upper bits zero, len_o=count, n=0.
//   - Slot busy: go to S_FLUSH.
//   - Flush coinciding with word completion is absorbed; the full word is emitted once.
// - S_FLUSH: load the partial word when the slot is free, then go to S_FILL. flush_i is ignored in S_STALL and S_FLUSH.
// - Output register: holds its value while val_o & !rdy_i. After Emit with no new load, val_o=0 and word_o/len_o keep their last value.
// - Ones counter:
//   - +1 on each Accept with Y_i=1; saturates at 2^CNT_W-1.
//   - A Y_i=1 accept at saturation sets ovf_o.
//   - Cleared only by reset.
// - Reset (async assert):
//   - val_o=0, word_o=0, len_o=0, ones_cnt_o=0, ovf_o=0, sr=0, n=0, state=S_FILL.
//   - rdy_o=0 while reset is asserted and 1 after release.
//   - A partial word is discarded; the next word starts at bit 0.
// - rdy_o is decoded from state only; no combinational path from rdy_i or val_i.
// CONFIGURATION
// - Macro PERCEPTRON_PACK_PARITY_EN.
// - Defined:
//   - Adds port parity_o (out, 1) = XOR of the valid bits of word_o.
//   - Registered with word_o; reset to 0; valid when val_o=1.
// - Undefined: no parity_o port and no parity logic; all other behaviour is identical.
// TESTING
// - PACK=8, rdy_i=1, Y=1,0,1,1,0,0,0,1 back-to-back -> val_o 1 cycle after the 8th accept; word_o=8'h8D, len_o=8, ones_cnt_o=4.
// - rdy_i=0, 16 accepts of Y=1 -> first 8'hFF held; rdy_o=0 after the 16th accept. Then rdy_i=1 -> 8'hFF twice in consecutive cycles; rdy_o returns to 1.
// - Y=1,1,0 then flush_i -> word_o=8'h03, len_o=3.
// - Flush in the same cycle as the 3rd accept -> len_o=3. Flush with n=0 -> no val_o.
// - CNT_W=4, 17 accepts of Y=1 -> ones_cnt_o=15, ovf_o=1.
// - 5 accepts, then reset low for 1 cycle -> val_o=0 immediately. 8 more accepts -> word contains only the new bits.
// - Parity build: Y=1,1,1,0,0,0,0,0 -> parity_o=1. Flushed 2-bit word 2'b11 -> parity_o=0.

Source files
------------

// File: rtl/perceptron_result_packer.sv
// Packs 1-bit perceptron decisions LSB-first into PACK-bit words with flush and a saturating ones counter.
// Optional parity output is enabled with `define PERCEPTRON_PACK_PARITY_EN.
module perceptron_result_packer #(
    parameter int unsigned PACK  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       val_i,
    output logic                       rdy_o,
    input  logic                       Y_i,
    input  logic                       flush_i,
    output logic                       val_o,
    input  logic                       rdy_i,
    output logic [PACK-1:0]            word_o,
    output logic [$clog2(PACK+1)-1:0]  len_o,
    output logic [CNT_W-1:0]           ones_cnt_o,
    output logic                       ovf_o
`ifdef PERCEPTRON_PACK_PARITY_EN
    ,
    output logic                       parity_o
`endif
);
    localparam int unsigned LW = $clog2(PACK+1);

    typedef enum logic [1:0] {S_FILL, S_STALL, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [PACK-1:0]   sr_q, sr_d, sr_acc;
    logic [LW-1:0]     n_q, n_d, n_acc;
    logic              val_o_q, val_o_d;
    logic [PACK-1:0]   word_q, word_d, load_word;
    logic [LW-1:0]     len_q, len_d, load_len;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              accept, slot_free, load;
`ifdef PERCEPTRON_PACK_PARITY_EN
    logic              par_q, par_d;
`endif

    // Held low during reset so upstream never sees a ready it cannot use.
    assign rdy_o     = reset && (state_q == S_FILL);
    assign accept    = val_i & rdy_o;
    assign slot_free = !val_o_q | rdy_i;

    always_comb begin
        sr_acc = sr_q;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (accept && (n_q == LW'(i))) sr_acc[i] = Y_i;
        end
        n_acc = n_q + LW'(accept);

        state_d   = state_q;
        sr_d      = sr_q;
        n_d       = n_q;
        val_o_d   = val_o_q & ~rdy_i;
        word_d    = word_q;
        len_d     = len_q;
        load      = 1'b0;
        load_word = '0;
        load_len  = '0;

        unique case (state_q)
            S_FILL: begin
                // Word completion takes priority, which absorbs a coincident flush.
                if (accept && (n_q == LW'(PACK-1))) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_word = sr_acc;
                        load_len  = LW'(PACK);
                    end else begin
                        sr_d    = sr_acc;
                        n_d     = n_acc;
                        state_d = S_STALL;
                    end
                end else if (flush_i && (n_acc != '0)) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_word = sr_acc;
                        load_len  = n_acc;
                    end else begin
                        sr_d    = sr_acc;
                        n_d     = n_acc;
                        state_d = S_FLUSH;
                    end
                end else begin
                    sr_d = sr_acc;
                    n_d  = n_acc;
                end
            end
            S_STALL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = sr_q;
                    load_len  = LW'(PACK);
                    state_d   = S_FILL;
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = sr_q;
                    load_len  = n_q;
                    state_d   = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        // Clearing sr on every load keeps the upper bits of partial words zero.
        if (load) begin
            val_o_d = 1'b1;
            word_d  = load_word;
            len_d   = load_len;
            sr_d    = '0;
            n_d     = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept && Y_i) begin
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef PERCEPTRON_PACK_PARITY_EN
    always_comb begin
        par_d = par_q;
        if (load) par_d = ^load_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign parity_o = par_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            sr_q    <= '0;
            n_q     <= '0;
            val_o_q <= 1'b0;
            word_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            n_q     <= n_d;
            val_o_q <= val_o_d;
            word_q  <= word_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign val_o      = val_o_q;
    assign word_o     = word_q;
    assign len_o      = len_q;
    assign ones_cnt_o = cnt_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_perceptron_result_packer.sv
// Scoreboard bench for perceptron_result_packer: a bit-list reference model queues expected words,
// an independent monitor pops and compares them on every output handshake.
module tb_perceptron_result_packer;
    localparam int unsigned PACK  = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LW    = $clog2(PACK+1);

    logic             clk, reset, val_i, rdy_o, Y_i, flush_i, val_o, rdy_i, ovf_o;
    logic [PACK-1:0]  word_o;
    logic [LW-1:0]    len_o;
    logic [CNT_W-1:0] ones_cnt_o;
`ifdef PERCEPTRON_PACK_PARITY_EN
    logic             parity_o;
`endif

    perceptron_result_packer #(.PACK(PACK), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .val_i(val_i), .rdy_o(rdy_o), .Y_i(Y_i),
        .flush_i(flush_i), .val_o(val_o), .rdy_i(rdy_i), .word_o(word_o),
        .len_o(len_o), .ones_cnt_o(ones_cnt_o), .ovf_o(ovf_o)
`ifdef PERCEPTRON_PACK_PARITY_EN
        , .parity_o(parity_o)
`endif
    );

    typedef struct {
        logic [PACK-1:0] word;
        int              len;
        logic            par;
    } exp_t;

    exp_t       exp_q[$];
    bit         bits[$];
    int         m_cnt;
    bit         m_ovf;
    int         stuck;
    int         chk, err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    function void push_word();
        exp_t e;
        e.word = '0;
        for (int k = 0; k < bits.size(); k++) e.word[k] = bits[k];
        e.len = bits.size();
        e.par = ^e.word;
        exp_q.push_back(e);
        bits.delete();
    endfunction

    // Reference model: sampled 2 time units before each rising edge.
    initial forever begin
        @(negedge clk); #3;
        if (reset) begin
            chk++;
            if (int'(ones_cnt_o) != m_cnt || ovf_o != m_ovf) begin
                err++;
                $display("FAIL ones_cnt: got cnt=%0d ovf=%0b, required cnt=%0d ovf=%0b",
                         ones_cnt_o, ovf_o, m_cnt, m_ovf);
            end
            chk++;
            if (rdy_o != (exp_q.size() < 2)) begin
                err++;
                $display("FAIL rdy_o: got %0b, required %0b (pending words %0d)",
                         rdy_o, exp_q.size() < 2, exp_q.size());
            end
            if (val_i && rdy_o) begin
                bits.push_back(Y_i);
                if (Y_i) begin
                    if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1'b1;
                    else                           m_cnt++;
                end
            end
            if (bits.size() == PACK)                           push_word();
            else if (flush_i && rdy_o && bits.size() > 0)      push_word();
        end
    end

    // Monitor: compares every emitted word against the head of the expected queue.
    initial forever begin
        @(negedge clk); #4;
        if (reset) begin
            if (val_o && rdy_i) begin
                stuck = 0;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL unexpected_word: got word=%h len=%0d, required no word", word_o, len_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (word_o != e.word || int'(len_o) != e.len) begin
                        err++;
                        $display("FAIL word: got word=%h len=%0d, required word=%h len=%0d",
                                 word_o, len_o, e.word, e.len);
                    end
`ifdef PERCEPTRON_PACK_PARITY_EN
                    chk++;
                    if (parity_o != e.par) begin
                        err++;
                        $display("FAIL parity: got %0b, required %0b", parity_o, e.par);
                    end
`endif
                end
            end else if (exp_q.size() > 0 && rdy_i) begin
                stuck++;
                if (stuck > 1) begin
                    chk++; err++;
                    $display("FAIL latency: got no word for %0d ready cycles, required at most 1", stuck);
                    stuck = 0;
                end
            end else begin
                stuck = 0;
            end
        end
    end

    task automatic chk_eq(input string name, input int got, input int exp);
        chk++;
        if (got != exp) begin
            err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic send(input bit y, input bit fl);
        int w;
        @(negedge clk);
        val_i = 1'b1; Y_i = y; flush_i = fl;
        #4;
        w = 0;
        while (!rdy_o && w < 50) begin
            @(negedge clk); #4;
            w++;
        end
        if (!rdy_o) begin
            chk++; err++;
            $display("FAIL accept_timeout: got rdy_o=0 for 50 cycles, required 1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            val_i = 1'b0; flush_i = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        val_i = 1'b0; flush_i = 1'b0;
        #4;
    endtask

    initial begin
        logic [7:0] pat;
        chk = 0; err = 0; m_cnt = 0; m_ovf = 0; stuck = 0;
        reset = 1'b0; val_i = 1'b0; Y_i = 1'b0; flush_i = 1'b0; rdy_i = 1'b0;

        repeat (2) @(negedge clk);
        #4;
        chk_eq("rst_val_o", val_o, 0);
        chk_eq("rst_word_o", word_o, 0);
        chk_eq("rst_len_o", len_o, 0);
        chk_eq("rst_ones_cnt", ones_cnt_o, 0);
        chk_eq("rst_ovf", ovf_o, 0);
        chk_eq("rst_rdy_o", rdy_o, 0);
        @(negedge clk);
        #1 reset = 1'b1; rdy_i = 1'b1;
        idle(2);

        // Back-to-back full word with an always-ready sink.
        pat = 8'h8D;
        for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
        settle();
        chk_eq("full_val_o_latency", val_o, 1);
        chk_eq("full_word", word_o, 8'h8D);
        chk_eq("full_len", len_o, 8);
        chk_eq("full_ones", ones_cnt_o, 4);
        idle(2);

        // Blocked sink: two full words back up and the input stalls.
        @(negedge clk); rdy_i = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0);
        settle();
        chk_eq("stall_rdy_o", rdy_o, 0);
        chk_eq("stall_word_held", word_o, 8'hFF);
        chk_eq("sat_ones", ones_cnt_o, 15);
        chk_eq("sat_ovf", ovf_o, 1);
        @(negedge clk); rdy_i = 1'b1;
        #4;
        chk_eq("drain1_val_o", val_o, 1);
        chk_eq("drain1_word", word_o, 8'hFF);
        @(negedge clk); #4;
        chk_eq("drain2_val_o", val_o, 1);
        chk_eq("drain2_word", word_o, 8'hFF);
        chk_eq("drain_rdy_o", rdy_o, 1);
        idle(2);

        // Flush after three accepts.
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
        @(negedge clk); val_i = 1'b0; flush_i = 1'b1;
        settle();
        chk_eq("flush3_word", word_o, 8'h03);
        chk_eq("flush3_len", len_o, 3);
        idle(2);

        send(1'b1, 1'b0); send(1'b1, 1'b0);
        @(negedge clk); val_i = 1'b0; flush_i = 1'b1;
        settle();
        chk_eq("flush2_word", word_o, 8'h03);
        chk_eq("flush2_len", len_o, 2);
`ifdef PERCEPTRON_PACK_PARITY_EN
        chk_eq("flush2_parity", parity_o, 0);
`endif
        idle(2);

        // Flush in the same cycle as the third accept.
        send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b1);
        settle();
        chk_eq("flush_same_word", word_o, 8'h05);
        chk_eq("flush_same_len", len_o, 3);
        idle(3);

        // Flush with nothing buffered produces no word.
        @(negedge clk); val_i = 1'b0; flush_i = 1'b1;
        settle();
        chk_eq("flush_empty_val_o", val_o, 0);
        idle(2);

        // Reset with a held word and a partial word.
        @(negedge clk); rdy_i = 1'b0;
        for (int i = 0; i < 8; i++) send(1'(i % 2), 1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        settle();
        chk_eq("pre_reset_val_o", val_o, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        exp_q.delete(); bits.delete(); m_cnt = 0; m_ovf = 0; stuck = 0;
        #1;
        chk_eq("async_rst_val_o", val_o, 0);
        chk_eq("async_rst_rdy_o", rdy_o, 0);
        chk_eq("async_rst_ones", ones_cnt_o, 0);
        @(negedge clk); rdy_i = 1'b1;
        #1 reset = 1'b1;
        pat = 8'h07;
        for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
        settle();
        chk_eq("post_reset_word", word_o, 8'h07);
        chk_eq("post_reset_len", len_o, 8);
`ifdef PERCEPTRON_PACK_PARITY_EN
        chk_eq("post_reset_parity", parity_o, 1);
`endif
        idle(2);

        // Randomized traffic with random backpressure and flushes.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rdy_i   = ($urandom_range(0, 9) < 7);
            val_i   = ($urandom_range(0, 3) != 0);
            Y_i     = 1'($urandom_range(0, 1));
            flush_i = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        val_i = 1'b0; flush_i = 1'b0; rdy_i = 1'b1;
        idle(10);
        #4;
        chk_eq("drain_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
